// File: rtl/pbit_pkg.sv
// Shared types and helpers for the p-bit readout engine.
package pbit_pkg;

    // State | meaning
    // IDLE   | waiting for start; last result still visible on sums
    // FLUSH  | holding the network in reset for FLUSH_CYCLES cycles
    // BURN   | discarding burn_in cycles while the network settles
    // SAMPLE | accumulating bipolar p-bit values for n_samples cycles
    // DONE   | result valid, waiting for the consumer to take it
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FLUSH  = 3'd1,
        BURN   = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } sampler_state_t;

    localparam int FLUSH_CYCLES = 2;

    // Maps a p-bit level onto its bipolar value: 1 -> +1, 0 -> -1.
    function automatic logic signed [1:0] bipolar(input logic b);
        return b ? 2'sd1 : -2'sd1;
    endfunction

endpackage

// File: rtl/pbit_accumulator.sv
// Signed up/down counter holding the running bipolar sum of one p-bit.
module pbit_accumulator
    import pbit_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear_i,
    input  logic                        enable_i,
    input  logic                        p_bit_i,
    output logic signed [CNT_WIDTH:0]   sum_o
);

    logic signed [1:0]         step_bp;
    logic signed [CNT_WIDTH:0] step;
    logic signed [CNT_WIDTH:0] sum_d;
    logic signed [CNT_WIDTH:0] sum_q;

    // Next sum: clear wins over accumulate; the +/-1 step is sign-extended to the sum width.
    always_comb begin
        step_bp = bipolar(p_bit_i);
        step    = {{(CNT_WIDTH - 1){step_bp[1]}}, step_bp};
        sum_d   = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (enable_i) begin
            sum_d = sum_q + step;
        end
    end

    // Sum register; an aborting reset discards any partial result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/pbit_sampler.sv
// Readout engine for a p-bit network: flush, burn-in, sample window, handshake.
//
// State  | meaning
// IDLE   | waiting for start; sums keep the previous result
// FLUSH  | net_reset high for FLUSH_CYCLES cycles
// BURN   | counting down burn_in discarded cycles
// SAMPLE | counting down n_samples accumulated cycles
// DONE   | sum_valid high until sum_ready
module pbit_sampler
    import pbit_pkg::*;
#(
    parameter int N_BITS    = 3,
    parameter int CNT_WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [CNT_WIDTH-1:0]                burn_in,
    input  logic [CNT_WIDTH-1:0]                n_samples,
    input  logic [N_BITS-1:0]                   p_bits,
    output logic                                net_reset,
    output logic                                busy,
    output logic [N_BITS*(CNT_WIDTH+1)-1:0]     sums,
    output logic                                sum_valid,
    input  logic                                sum_ready
);

    localparam int SUM_W   = CNT_WIDTH + 1;
    localparam int FLUSH_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [FLUSH_W-1:0]   FLUSH_ONE  = FLUSH_W'(1);
    localparam logic [FLUSH_W-1:0]   FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    sampler_state_t       state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] burn_q;
    logic [CNT_WIDTH-1:0] samples_q;
    logic [FLUSH_W-1:0]   flush_cnt_q;
    logic                 net_reset_q;
    logic                 busy_q;
    logic                 sum_valid_q;

    logic                 acc_clear;
    logic                 acc_enable;

    // Sums are cleared on the accepted start and accumulate on every SAMPLE cycle.
    assign acc_clear  = (state_q == IDLE) && start;
    assign acc_enable = (state_q == SAMPLE);

    // Sequencer: one shared down-counter serves BURN and SAMPLE; zero-length phases are skipped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            burn_q      <= '0;
            samples_q   <= '0;
            flush_cnt_q <= '0;
            net_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        burn_q      <= burn_in;
                        samples_q   <= n_samples;
                        flush_cnt_q <= FLUSH_LAST;
                        net_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == '0) begin
                        net_reset_q <= 1'b0;
                        if (burn_q != '0) begin
                            cnt_q   <= burn_q - CNT_ONE;
                            state_q <= BURN;
                        end else if (samples_q != '0) begin
                            cnt_q   <= samples_q - CNT_ONE;
                            state_q <= SAMPLE;
                        end else begin
                            sum_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else begin
                        flush_cnt_q <= flush_cnt_q - FLUSH_ONE;
                    end
                end
                BURN: begin
                    if (cnt_q == '0) begin
                        if (samples_q != '0) begin
                            cnt_q   <= samples_q - CNT_ONE;
                            state_q <= SAMPLE;
                        end else begin
                            sum_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                SAMPLE: begin
                    if (cnt_q == '0) begin
                        sum_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        sum_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign net_reset = net_reset_q;
    assign busy      = busy_q;
    assign sum_valid = sum_valid_q;

    for (genvar i = 0; i < N_BITS; i++) begin : g_acc
        pbit_accumulator #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_acc (
            .clk      (clk),
            .reset    (reset),
            .clear_i  (acc_clear),
            .enable_i (acc_enable),
            .p_bit_i  (p_bits[i]),
            .sum_o    (sums[i*SUM_W +: SUM_W])
        );
    end

endmodule

// File: tb/tb_pbit_sampler.sv
// Scoreboard bench for pbit_sampler: stimulus pushes expected results, a monitor checks them.
module tb_pbit_sampler;

    localparam int N  = 3;
    localparam int CW = 16;
    localparam int SW = CW + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [CW-1:0]   burn_in;
    logic [CW-1:0]   n_samples;
    logic [N-1:0]    p_bits;
    logic            net_reset;
    logic            busy;
    logic [N*SW-1:0] sums;
    logic            sum_valid;
    logic            sum_ready;

    logic            start4;
    logic [3:0]      burn4;
    logic [3:0]      n4;
    logic [N-1:0]    p4;
    logic            net_reset4;
    logic            busy4;
    logic [N*5-1:0]  sums4;
    logic            sum_valid4;
    logic            sum_ready4;

    always #5 clk = ~clk;

    pbit_sampler #(.N_BITS(N), .CNT_WIDTH(CW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .burn_in   (burn_in),
        .n_samples (n_samples),
        .p_bits    (p_bits),
        .net_reset (net_reset),
        .busy      (busy),
        .sums      (sums),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready)
    );

    pbit_sampler #(.N_BITS(N), .CNT_WIDTH(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start4),
        .burn_in   (burn4),
        .n_samples (n4),
        .p_bits    (p4),
        .net_reset (net_reset4),
        .busy      (busy4),
        .sums      (sums4),
        .sum_valid (sum_valid4),
        .sum_ready (sum_ready4)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N*SW-1:0] sums;
        int              t_valid;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Inputs change just after a rising edge and are used by the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation when sum_valid appears, then tracks stability and the handshake.
    bit   in_xfer      = 1'b0;
    bit   pending_idle = 1'b0;
    exp_t cur;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_xfer      = 1'b0;
                pending_idle = 1'b0;
            end else begin
                if (pending_idle) begin
                    check("idle_busy", busy, 0);
                    check("idle_valid", sum_valid, 0);
                    check("idle_sums_held", sums, cur.sums);
                    pending_idle = 1'b0;
                    in_xfer      = 1'b0;
                end
                if (sum_valid) begin
                    if (!in_xfer) begin
                        in_xfer = 1'b1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_valid: sum_valid high with no run pending (cycle %0d)", cyc);
                            cur.sums    = sums;
                            cur.t_valid = cyc + 1;
                        end else begin
                            cur = exp_q.pop_front();
                            check("valid_edge", cyc + 1, cur.t_valid);
                            check("sums", sums, cur.sums);
                            check("busy_in_done", busy, 1);
                        end
                    end else begin
                        check("sums_stable", sums, cur.sums);
                    end
                    if (sum_ready) pending_idle = 1'b1;
                end
            end
        end
    end

    // One run. mode: 0 constant cval, 1 bit0 alternates from 1 in the window, 2 uniform random, 3 biased to 1.
    task automatic run(input int burn, input int n, input int mode, input logic [N-1:0] cval, input int hold);
        int             len;
        int             k;
        int             acc[N];
        logic [N-1:0]   v;
        logic [N-1:0]   seq[$];
        exp_t           e;
        int             t0;
        len = 3 + burn + n;
        for (int i = 0; i < N; i++) acc[i] = 0;
        for (int j = 0; j < len; j++) begin
            v = N'($urandom);
            case (mode)
                0: v = cval;
                1: if (j >= 3 + burn) v[0] = (((j - 3 - burn) % 2) == 0);
                3: for (int i = 0; i < N; i++) v[i] = ($urandom_range(99) < 85);
                default: ;
            endcase
            seq.push_back(v);
            if (j >= 3 + burn && j <= 2 + burn + n)
                for (int i = 0; i < N; i++) acc[i] += v[i] ? 1 : -1;
        end
        step();
        t0        = cyc + 1;
        e.t_valid = t0 + 3 + burn + n;
        for (int i = 0; i < N; i++) e.sums[i*SW +: SW] = SW'(acc[i]);
        exp_q.push_back(e);
        start     = 1'b1;
        burn_in   = CW'(burn);
        n_samples = CW'(n);
        p_bits    = seq[0];
        sum_ready = (hold == 0);
        for (int j = 1; j < len; j++) begin
            step();
            start     = 1'b0;
            burn_in   = CW'($urandom);
            n_samples = CW'($urandom);
            p_bits    = seq[j];
            if (j <= 3) check("net_reset_window", net_reset, (j <= 2));
            check("busy_run", busy, 1);
        end
        step();
        p_bits = N'($urandom);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                check("bp_busy", busy, 1);
                check("bp_valid", sum_valid, 1);
                start = 1'($urandom_range(1));
                step();
            end
            start     = 1'b0;
            sum_ready = 1'b1;
            step();
            sum_ready = 1'b0;
        end
        k = 0;
        while ((busy || sum_valid) && k < 50) begin
            step();
            k++;
        end
        check("run_end_busy", busy, 0);
        sum_ready = 1'b0;
    endtask

    // Aborted run: reset pulled low part-way into SAMPLE.
    task automatic run_abort(input int burn);
        step();
        start     = 1'b1;
        burn_in   = CW'(burn);
        n_samples = CW'(20);
        sum_ready = 1'b1;
        p_bits    = N'($urandom);
        for (int j = 1; j <= 3 + burn + 5; j++) begin
            step();
            start  = 1'b0;
            p_bits = N'($urandom);
        end
        reset = 1'b0;
        #1;
        check("abort_net_reset", net_reset, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", sum_valid, 0);
        check("abort_sums", sums, 0);
        step();
        reset = 1'b1;
        step();
        check("abort_idle_busy", busy, 0);
    endtask

    initial begin
        int k;
        reset      = 1'b0;
        start      = 1'b0;
        burn_in    = '0;
        n_samples  = '0;
        p_bits     = '0;
        sum_ready  = 1'b0;
        start4     = 1'b0;
        burn4      = '0;
        n4         = '0;
        p4         = '0;
        sum_ready4 = 1'b0;
        repeat (3) step();
        check("rst_net_reset", net_reset, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", sum_valid, 0);
        check("rst_sums", sums, 0);
        check("rst_sums4", sums4, 0);
        reset = 1'b1;
        step();

        run(4, 10, 0, 3'b101, 0);
        run(2, 8, 1, '0, 0);
        run(3, 7, 1, '0, 1);
        run(0, 0, 2, '0, 0);
        run(0, 1, 2, '0, 0);
        run(1, 6, 2, '0, 20);
        run_abort(2);
        run(1, 12, 2, '0, 0);
        for (int r = 0; r < 10; r++)
            run($urandom_range(6), $urandom_range(40), 2, '0, $urandom_range(3));
        run(2, 1000, 3, '0, 0);

        step();
        start4     = 1'b1;
        burn4      = 4'd0;
        n4         = 4'd15;
        p4         = '0;
        sum_ready4 = 1'b0;
        step();
        start4 = 1'b0;
        k = 0;
        while (!sum_valid4 && k < 40) begin
            step();
            k++;
        end
        check("cw4_valid", sum_valid4, 1);
        check("cw4_sums", sums4, 15'b10001_10001_10001);
        sum_ready4 = 1'b1;
        step();
        sum_ready4 = 1'b0;
        step();
        check("cw4_busy_after", busy4, 0);

        repeat (3) step();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
